// File: rtl/sme_rng_feed.sv
// sme_rng_feed: randomness supply for the SME ALU guard-share bus.
//
// A 32-bit Galois LFSR produces one word per cycle into a word buffer. Once
// RMAX = SMAX + SMAX*(SMAX-1)/2 words are collected the bundle is presented
// on rng with rng_valid high, and it is consumed at most once by rng_take.
//
// Ports:
//   g_clk       in   clock (single domain)
//   g_resetn    in   synchronous active-low reset
//   g_clk_req   out  clock request: high while filling or seeding
//   seed_valid  in   load seed into the LFSR and discard buffered words
//   seed        in   new LFSR state (0 is replaced by 1)
//   rng_take    in   consumer accepts the current bundle
//   rng_valid   out  a complete, unused bundle is on rng
//   rng         out  RMAX words, word i at rng[i*XLEN +: XLEN]; zero when invalid
//
// Optional feature macro: SME_RNG_FEED_DBUF_EN
//   Two RMAX-word banks; the inactive bank is filled in the background so a
//   take can swap banks without dropping rng_valid.

module sme_rng_feed #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SMAX       = 4,
  parameter logic [31:0] LFSR_RESET = 32'h0000_0001,
  localparam int unsigned RMAX      = SMAX + SMAX * (SMAX - 1) / 2,
  localparam int unsigned RW        = RMAX * XLEN - 1
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  output logic          g_clk_req,
  input  logic          seed_valid,
  input  logic [31:0]   seed,
  input  logic          rng_take,
  output logic          rng_valid,
  output logic [RW:0]   rng
);

  localparam int unsigned CW   = $clog2(RMAX + 1);
  localparam int unsigned IW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  // Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0000_0000);
  endfunction

  logic [31:0]   lfsr_q;
  logic          valid_q;
  logic          take;
  logic [RW:0]   rng_flat;

  assign take      = rng_take && valid_q;
  assign rng_valid = valid_q;
  // Never expose stale masks.
  assign rng       = valid_q ? rng_flat : '0;

`ifdef SME_RNG_FEED_DBUF_EN

  logic [XLEN-1:0] bank_q [2][RMAX];
  logic            act_q;
  logic [CW-1:0]   cnt_a_q;   // words in the active bank
  logic [CW-1:0]   cnt_i_q;   // words in the inactive bank

  // A take always swaps banks: if the inactive bank is full the bundle is
  // replaced immediately, otherwise the partially filled bank becomes active
  // and finishes filling while rng_valid is low.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lfsr_q  <= LFSR_RESET;
      act_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_i_q <= '0;
      valid_q <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < RMAX; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (seed_valid) begin
      lfsr_q  <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
      cnt_a_q <= '0;
      cnt_i_q <= '0;
      valid_q <= 1'b0;
    end else if (take) begin
      act_q   <= ~act_q;
      cnt_a_q <= cnt_i_q;
      cnt_i_q <= '0;
      valid_q <= (cnt_i_q == CW'(RMAX));
    end else if (cnt_a_q != CW'(RMAX)) begin
      bank_q[act_q][cnt_a_q[IW-1:0]] <= XLEN'(lfsr_q);
      lfsr_q  <= lfsr_step(lfsr_q);
      cnt_a_q <= cnt_a_q + CW'(1);
      valid_q <= (cnt_a_q == CW'(RMAX - 1));
    end else if (cnt_i_q != CW'(RMAX)) begin
      bank_q[~act_q][cnt_i_q[IW-1:0]] <= XLEN'(lfsr_q);
      lfsr_q  <= lfsr_step(lfsr_q);
      cnt_i_q <= cnt_i_q + CW'(1);
    end
  end

  // Flatten the active bank onto the output bus.
  always_comb begin
    rng_flat = '0;
    for (int unsigned i = 0; i < RMAX; i++) begin
      rng_flat[i*XLEN +: XLEN] = bank_q[act_q][i];
    end
  end

  assign g_clk_req = (cnt_a_q != CW'(RMAX)) || (cnt_i_q != CW'(RMAX)) || seed_valid;

`else

  logic [XLEN-1:0] word_q [RMAX];
  logic [CW-1:0]   cnt_q;

  // Seed beats take beats fill; take edges write nothing and hold the LFSR.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lfsr_q  <= LFSR_RESET;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < RMAX; i++) begin
        word_q[i] <= '0;
      end
    end else if (seed_valid) begin
      lfsr_q  <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (take) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (cnt_q != CW'(RMAX)) begin
      word_q[cnt_q[IW-1:0]] <= XLEN'(lfsr_q);
      lfsr_q  <= lfsr_step(lfsr_q);
      cnt_q   <= cnt_q + CW'(1);
      valid_q <= (cnt_q == CW'(RMAX - 1));
    end
  end

  // Flatten the buffer onto the output bus.
  always_comb begin
    rng_flat = '0;
    for (int unsigned i = 0; i < RMAX; i++) begin
      rng_flat[i*XLEN +: XLEN] = word_q[i];
    end
  end

  assign g_clk_req = (cnt_q != CW'(RMAX)) || seed_valid;

`endif

endmodule

// File: tb/tb_sme_rng_feed.sv
// Directed bench for sme_rng_feed with SMAX=4 (RMAX=10), LFSR_RESET=1.
module tb_sme_rng_feed;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SMAX = 4;
  localparam int unsigned RMAX = 10;
  localparam int unsigned RW   = RMAX * XLEN - 1;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          g_clk_req;
  logic          seed_valid;
  logic [31:0]   seed;
  logic          rng_take;
  logic          rng_valid;
  logic [RW:0]   rng;

  int checks   = 0;
  int failures = 0;

  // Expected LFSR word stream starting from state 1.
  logic [31:0] exp_seq [48];

  sme_rng_feed #(
    .XLEN(XLEN),
    .SMAX(SMAX),
    .LFSR_RESET(32'h0000_0001)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .g_clk_req(g_clk_req),
    .seed_valid(seed_valid),
    .seed(seed),
    .rng_take(rng_take),
    .rng_valid(rng_valid),
    .rng(rng)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] word(input int i);
    return rng[i*XLEN +: XLEN];
  endfunction

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] k [4];
    k[0] = 32'h0000_0001; k[1] = 32'h8020_0003;
    k[2] = 32'hC030_0002; k[3] = 32'h6018_0001;
    g_resetn = 1'b0; seed_valid = 1'b0; rng_take = 1'b0; seed = 32'h0;
    step(); step();
    checks++;
    if (rng_valid !== 1'b0 || rng !== '0 || g_clk_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_state valid=%b rng_nonzero=%b clk_req=%b expected 0/0/1",
               rng_valid, |rng, g_clk_req);
    end
    g_resetn = 1'b1;
    for (int e = 1; e <= int'(RMAX); e++) begin
      step();
      checks++;
      if (e < int'(RMAX)) begin
        if (rng_valid !== 1'b0 || rng !== '0) begin
          failures++;
          $display("FAIL first_fill_gated edge=%0d valid=%b rng_nonzero=%b expected 0/0",
                   e, rng_valid, |rng);
        end
      end else if (rng_valid !== 1'b1) begin
        failures++;
        $display("FAIL first_valid edge=%0d valid=%b expected 1", e, rng_valid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word(i) !== k[i]) begin
        failures++;
        $display("FAIL first_word%0d got=%h expected=%h", i, word(i), k[i]);
      end
    end
    // Bundle must remain stable while unconsumed.
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < int'(RMAX); i++) begin
        checks++;
        if (rng_valid !== 1'b1 || word(i) !== exp_seq[i]) begin
          failures++;
          $display("FAIL stable_word%0d cyc=%0d valid=%b got=%h expected=%h",
                   i, c, rng_valid, word(i), exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_take();
    checks++;
    if (g_clk_req !== 1'b0) begin
      failures++;
      $display("FAIL clk_req_idle got=%b expected 0", g_clk_req);
    end
    rng_take = 1'b1;
    step();
    checks++;
    if (rng_valid !== 1'b0 || rng !== '0) begin
      failures++;
      $display("FAIL take_clear valid=%b rng_nonzero=%b expected 0/0", rng_valid, |rng);
    end
    // rng_take stays high through the refill window and must be ignored.
    for (int k = 1; k <= int'(RMAX); k++) begin
      step();
      checks++;
      if (k < int'(RMAX)) begin
        if (rng_valid !== 1'b0 || g_clk_req !== 1'b1) begin
          failures++;
          $display("FAIL take_refill_low k=%0d valid=%b clk_req=%b expected 0/1",
                   k, rng_valid, g_clk_req);
        end
      end else if (rng_valid !== 1'b1) begin
        failures++;
        $display("FAIL take_refill_valid k=%0d valid=%b expected 1", k, rng_valid);
      end
    end
    rng_take = 1'b0;
    for (int i = 0; i < int'(RMAX); i++) begin
      checks++;
      if (word(i) !== exp_seq[10+i]) begin
        failures++;
        $display("FAIL take_word%0d got=%h expected=%h", i, word(i), exp_seq[10+i]);
      end
    end
  endtask

  task automatic test_seed_zero();
    rng_take = 1'b1;
    step();
    rng_take = 1'b0;
    step(); step(); step();
    seed = 32'h0; seed_valid = 1'b1;
    step();
    seed_valid = 1'b0;
    for (int k = 1; k <= int'(RMAX); k++) begin
      step();
      checks++;
      if (k < int'(RMAX)) begin
        if (rng_valid !== 1'b0) begin
          failures++;
          $display("FAIL seed0_refill_low k=%0d valid=%b expected 0", k, rng_valid);
        end
      end else if (rng_valid !== 1'b1) begin
        failures++;
        $display("FAIL seed0_valid k=%0d valid=%b expected 1", k, rng_valid);
      end
    end
    checks++;
    if (word(0) !== 32'h0000_0001 || word(1) !== 32'h8020_0003) begin
      failures++;
      $display("FAIL seed0_words w0=%h w1=%h expected 00000001/80200003", word(0), word(1));
    end
  endtask

  task automatic test_seed_take();
    seed = 32'h6018_0001; seed_valid = 1'b1; rng_take = 1'b1;
    #1;
    checks++;
    if (g_clk_req !== 1'b1) begin
      failures++;
      $display("FAIL seed_clk_req got=%b expected 1", g_clk_req);
    end
    step();
    seed_valid = 1'b0; rng_take = 1'b0;
    checks++;
    if (rng_valid !== 1'b0 || rng !== '0) begin
      failures++;
      $display("FAIL seed_take_drop valid=%b rng_nonzero=%b expected 0/0", rng_valid, |rng);
    end
    for (int k = 1; k <= int'(RMAX); k++) begin
      step();
      checks++;
      if (rng_valid !== ((k == int'(RMAX)) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL seed_take_refill k=%0d valid=%b", k, rng_valid);
      end
    end
    checks++;
    if (word(0) !== 32'h6018_0001 || word(1) !== exp_seq[4]) begin
      failures++;
      $display("FAIL seed_take_words w0=%h w1=%h expected 60180001/%h",
               word(0), word(1), exp_seq[4]);
    end
  endtask

  task automatic test_reset_mid();
    rng_take = 1'b1;
    step();
    rng_take = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (rng_valid !== 1'b0 || g_clk_req !== 1'b1) begin
      failures++;
      $display("FAIL midfill_state valid=%b clk_req=%b expected 0/1", rng_valid, g_clk_req);
    end
    test_reset();
  endtask

`ifdef SME_RNG_FEED_DBUF_EN
  task automatic test_dbuf();
    // test_reset left us 13 edges after release; finish filling bank B.
    for (int k = 0; k < 7; k++) step();
    checks++;
    if (g_clk_req !== 1'b0 || rng_valid !== 1'b1) begin
      failures++;
      $display("FAIL dbuf_full clk_req=%b valid=%b expected 0/1", g_clk_req, rng_valid);
    end
    rng_take = 1'b1;
    step();
    checks++;
    if (rng_valid !== 1'b1 || word(0) !== exp_seq[10] || word(9) !== exp_seq[19]) begin
      failures++;
      $display("FAIL dbuf_swap valid=%b w0=%h w9=%h expected 1/%h/%h",
               rng_valid, word(0), word(9), exp_seq[10], exp_seq[19]);
    end
    step();
    rng_take = 1'b0;
    checks++;
    if (rng_valid !== 1'b0 || rng !== '0) begin
      failures++;
      $display("FAIL dbuf_second_take valid=%b rng_nonzero=%b expected 0/0", rng_valid, |rng);
    end
    for (int k = 1; k <= int'(RMAX); k++) begin
      step();
      checks++;
      if (rng_valid !== ((k == int'(RMAX)) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL dbuf_refill k=%0d valid=%b", k, rng_valid);
      end
    end
    checks++;
    if (word(0) !== exp_seq[20]) begin
      failures++;
      $display("FAIL dbuf_refill_word0 got=%h expected=%h", word(0), exp_seq[20]);
    end
  endtask
`endif

  initial begin
    exp_seq[0] = 32'h0000_0001;
    for (int i = 1; i < 48; i++) exp_seq[i] = nxt(exp_seq[i-1]);
    test_reset();
`ifdef SME_RNG_FEED_DBUF_EN
    test_dbuf();
`else
    test_take();
    test_seed_zero();
    test_seed_take();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
